tdc_pkt_rr_arbiter: RTL and testbench

// - Merges the 34-bit raw AMT packets from NCH parallel tdc_decoder_2bits lanes into one stream.
// - Each lane has a 1-entry hold register. A round-robin scheduler grants one pending lane per cycle.
// - The output is registered with a valid/ready handshake.
// - Sits between the per-TDC decoder bank (one copy c1 or c2) and the downstream event-builder FIFO.

---
 rtl/tdc_pkt_pkg.sv | 36 +++
 rtl/tdc_pkt_hold.sv | 85 ++++++++
 rtl/tdc_pkt_rr_arbiter.sv | 139 +++++++++++++
 tb/tb_tdc_pkt_rr_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdc_pkt_pkg
// Description : Shared constants for the 34-bit raw AMT packet. Field
//               positions are shared with the decoder debug wrapper.
//               Layout: type[33:30] id[29:26] chnum[25:21] edge[20] data[19:0]
// Revision    : 1.0 - initial release
// ============================================================================
package tdc_pkt_pkg;

    localparam int PKT_W     = 34;

    localparam int TYPE_MSB  = 33;
    localparam int TYPE_LSB  = 30;
    localparam int ID_MSB    = 29;
    localparam int ID_LSB    = 26;
    localparam int CHNUM_MSB = 25;
    localparam int CHNUM_LSB = 21;
    localparam int EDGE_BIT  = 20;
    localparam int DATA_MSB  = 19;
    localparam int DATA_LSB  = 0;

    localparam int TYPE_W    = TYPE_MSB - TYPE_LSB + 1;

    // Packets carrying this type are filler and never enter the arbiter.
    localparam logic [TYPE_W-1:0] IDLE_TYPE = 4'd0;

    typedef logic [PKT_W-1:0] pkt_t;

    function automatic logic [TYPE_W-1:0] pkt_type(input pkt_t p);
        return p[TYPE_MSB:TYPE_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/tdc_pkt_hold.sv
`default_nettype none
// ============================================================================
// Module      : tdc_pkt_hold
// Description : One-entry hold register for a single decoder lane, with the
//               capture/drop decision and a saturating drop counter.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               i_lane_en       - lane enable (gates capture)
//               i_pkt_valid     - new packet strobe
//               i_pkt, i_perr   - packet and its parity flag
//               grant_i         - hold entry is moved to the output this cycle
//               cnt_clr         - synchronous clear of the drop counter
//               pending_o       - hold entry is occupied
//               data_o, perr_o  - held packet and parity flag
//               drop_cnt_o      - saturating count of lost packets
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_pkt_hold
    import tdc_pkt_pkg::*;
#(
    parameter int                CNT_W    = 16,
    parameter logic [TYPE_W-1:0] IDLE_VAL = IDLE_TYPE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_lane_en,
    input  logic             i_pkt_valid,
    input  pkt_t             i_pkt,
    input  logic             i_perr,
    input  logic             grant_i,
    input  logic             cnt_clr,
    output logic             pending_o,
    output pkt_t             data_o,
    output logic             perr_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    logic             r_pending;
    pkt_t             r_data;
    logic             r_perr;
    logic [CNT_W-1:0] r_drop_cnt;

    logic w_req;
    logic w_take;
    logic w_drop;
    logic w_sat;

    assign w_req  = i_pkt_valid & i_lane_en & (pkt_type(i_pkt) != IDLE_VAL);
    // A slot being granted this cycle is free for the incoming packet, so a
    // lane can sustain one packet per cycle without losses.
    assign w_take = w_req & (~r_pending | grant_i);
    assign w_drop = w_req & r_pending & ~grant_i;
    assign w_sat  = &r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending  <= 1'b0;
            r_data     <= '0;
            r_perr     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_take) begin
                r_data    <= i_pkt;
                r_perr    <= i_perr;
                r_pending <= 1'b1;
            end else if (grant_i) begin
                r_pending <= 1'b0;
            end

            // Clear has priority over a simultaneous drop.
            if (cnt_clr) begin
                r_drop_cnt <= '0;
            end else if (w_drop && !w_sat) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign pending_o  = r_pending;
    assign data_o     = r_data;
    assign perr_o     = r_perr;
    assign drop_cnt_o = r_drop_cnt;

endmodule

`default_nettype wire

// File: rtl/tdc_pkt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tdc_pkt_rr_arbiter
// Description : Merges NCH decoder lanes into one valid/ready packet stream
//               using per-lane hold registers and a round-robin scheduler.
// Ports       : RX_FRAMECLK_I  - frame clock
//               user_rst       - asynchronous active-high reset
//               lane_en        - per-lane enable
//               pkt_valid      - per-lane new packet strobe
//               pkt_raw        - lane i packet at [i*PKT_W +: PKT_W]
//               pkt_parity_err - per-lane parity flag
//               cnt_clr        - clear all drop counters
//               out_valid/out_ready/out_data/out_lane/out_parity_err
//                              - registered output stream
//               drop_cnt       - lane i counter at [i*CNT_W +: CNT_W]
//               busy           - any packet pending or on the output
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_pkt_rr_arbiter #(
    parameter int         NCH       = 5,
    parameter int         PKT_W     = tdc_pkt_pkg::PKT_W,
    parameter int         CNT_W     = 16,
    parameter logic [3:0] IDLE_TYPE = tdc_pkt_pkg::IDLE_TYPE,
    localparam int        LANE_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   RX_FRAMECLK_I,
    input  logic                   user_rst,
    input  logic [NCH-1:0]         lane_en,
    input  logic [NCH-1:0]         pkt_valid,
    input  logic [NCH*PKT_W-1:0]   pkt_raw,
    input  logic [NCH-1:0]         pkt_parity_err,
    input  logic                   cnt_clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PKT_W-1:0]       out_data,
    output logic [LANE_W-1:0]      out_lane,
    output logic                   out_parity_err,
    output logic [NCH*CNT_W-1:0]   drop_cnt,
    output logic                   busy
);

    logic [NCH-1:0]    w_pending;
    logic [NCH-1:0]    w_elig;
    logic [NCH-1:0]    w_grant;
    logic [PKT_W-1:0]  w_hold_data [NCH];
    logic [NCH-1:0]    w_hold_perr;

    logic              w_load;
    logic              w_found;
    logic [LANE_W-1:0] w_gnt_idx;
    int                w_pos;

    logic              r_out_valid;
    logic [PKT_W-1:0]  r_out_data;
    logic [LANE_W-1:0] r_out_lane;
    logic              r_out_perr;
    logic [LANE_W-1:0] r_rr_ptr;

    // ------------------------------------------------------------------
    // Per-lane hold registers
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
            assign w_grant[gi] = w_load & w_found & (w_gnt_idx == LANE_W'(gi));

            tdc_pkt_hold #(
                .CNT_W    (CNT_W),
                .IDLE_VAL (IDLE_TYPE)
            ) u_hold (
                .clk         (RX_FRAMECLK_I),
                .rst         (user_rst),
                .i_lane_en   (lane_en[gi]),
                .i_pkt_valid (pkt_valid[gi]),
                .i_pkt       (pkt_raw[gi*PKT_W +: PKT_W]),
                .i_perr      (pkt_parity_err[gi]),
                .grant_i     (w_grant[gi]),
                .cnt_clr     (cnt_clr),
                .pending_o   (w_pending[gi]),
                .data_o      (w_hold_data[gi]),
                .perr_o      (w_hold_perr[gi]),
                .drop_cnt_o  (drop_cnt[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

    // A held packet on a disabled lane stays pending but is invisible to
    // the scheduler until the lane is enabled again.
    assign w_elig = w_pending & lane_en;
    assign w_load = ~r_out_valid | out_ready;

    // ------------------------------------------------------------------
    // Rotate-priority search starting one past the last granted lane.
    // ------------------------------------------------------------------
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_pos     = 0;
        for (int k = 1; k <= NCH; k++) begin
            w_pos = int'(r_rr_ptr) + k;
            if (w_pos >= NCH) begin
                w_pos = w_pos - NCH;
            end
            if (!w_found && w_elig[w_pos[LANE_W-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_pos[LANE_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register; frozen while stalled so out_* stays stable.
    // ------------------------------------------------------------------
    always_ff @(posedge RX_FRAMECLK_I or posedge user_rst) begin
        if (user_rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_lane  <= '0;
            r_out_perr  <= 1'b0;
            r_rr_ptr    <= LANE_W'(NCH - 1);
        end else if (w_load) begin
            r_out_valid <= w_found;
            if (w_found) begin
                r_out_data <= w_hold_data[w_gnt_idx];
                r_out_lane <= w_gnt_idx;
                r_out_perr <= w_hold_perr[w_gnt_idx];
                r_rr_ptr   <= w_gnt_idx;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign out_lane       = r_out_lane;
    assign out_parity_err = r_out_perr;
    assign busy           = (|w_pending) | r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_tdc_pkt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdc_pkt_rr_arbiter
// Description : Self-checking bench for tdc_pkt_rr_arbiter: directed table,
//               hand-written corner sequences and random traffic compared
//               against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_pkt_rr_arbiter;

    localparam int NCH   = 5;
    localparam int PKT_W = 34;
    localparam int CNT_W = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       lane_en;
    logic [NCH-1:0]       pkt_valid;
    logic [NCH*PKT_W-1:0] pkt_raw;
    logic [NCH-1:0]       perr;
    logic                 cnt_clr;
    logic                 out_ready;
    logic                 out_valid;
    logic [PKT_W-1:0]     out_data;
    logic [2:0]           out_lane;
    logic                 out_parity_err;
    logic [NCH*CNT_W-1:0] drop_cnt;
    logic                 busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tdc_pkt_rr_arbiter dut (
        .RX_FRAMECLK_I  (clk),
        .user_rst       (rst),
        .lane_en        (lane_en),
        .pkt_valid      (pkt_valid),
        .pkt_raw        (pkt_raw),
        .pkt_parity_err (perr),
        .cnt_clr        (cnt_clr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_lane       (out_lane),
        .out_parity_err (out_parity_err),
        .drop_cnt       (drop_cnt),
        .busy           (busy)
    );

    // ---------------- reference model ----------------
    bit               m_pend [NCH];
    logic [PKT_W-1:0] m_hold [NCH];
    bit               m_perr [NCH];
    int               m_drop [NCH];
    bit               m_ov;
    logic [PKT_W-1:0] m_od;
    int               m_ol;
    bit               m_operr;
    int               m_rr;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_pend[i] = 0; m_hold[i] = '0; m_perr[i] = 0; m_drop[i] = 0;
        end
        m_ov = 0; m_od = '0; m_ol = 0; m_operr = 0; m_rr = NCH - 1;
    endtask

    // Applies one clock edge worth of the arbiter rules to the model.
    task automatic model_step();
        int g;
        bit load;
        logic [PKT_W-1:0] p;
        load = !m_ov || out_ready;
        g = -1;
        if (load) begin
            for (int k = 1; k <= NCH; k++) begin
                int j;
                j = (m_rr + k) % NCH;
                if (g < 0 && m_pend[j] && lane_en[j]) g = j;
            end
            m_ov = (g >= 0);
            if (g >= 0) begin
                m_od = m_hold[g]; m_ol = g; m_operr = m_perr[g]; m_rr = g;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            p = pkt_raw[i*PKT_W +: PKT_W];
            if (pkt_valid[i] && lane_en[i] && p[33:30] != 4'd0) begin
                if (!m_pend[i] || g == i) begin
                    m_hold[i] = p; m_perr[i] = perr[i]; m_pend[i] = 1;
                end else if (m_drop[i] < 65535) begin
                    m_drop[i]++;
                end
            end else if (g == i) begin
                m_pend[i] = 0;
            end
            if (cnt_clr) m_drop[i] = 0;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PKT_W-1:0] mkpkt(input int lane, input int seq);
        return {4'h5, 4'(lane), 26'(seq)};
    endfunction

    task automatic set_lane(input int i, input logic [PKT_W-1:0] p, input logic pe);
        pkt_raw[i*PKT_W +: PKT_W] = p;
        perr[i] = pe;
    endtask

    task automatic compare_model();
        bit any;
        any = m_ov;
        for (int i = 0; i < NCH; i++) any = any | m_pend[i];
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_data", 64'(out_data), 64'(m_od));
        chk("out_lane", 64'(out_lane), 64'(m_ol));
        chk("out_parity_err", 64'(out_parity_err), 64'(m_operr));
        chk("busy", 64'(busy), 64'(any));
        for (int i = 0; i < NCH; i++)
            chk("drop_cnt", 64'(drop_cnt[i*CNT_W +: CNT_W]), 64'(m_drop[i]));
    endtask

    // Inputs are set at the falling edge; one rising edge; outputs compared
    // at the next falling edge; single-cycle strobes then cleared.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_model();
        pkt_valid = '0;
        cnt_clr   = 1'b0;
        perr      = '0;
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_valid"}, 64'(out_valid), 64'd0);
        chk({name, "_data"}, 64'(out_data), 64'd0);
        chk({name, "_lane"}, 64'(out_lane), 64'd0);
        chk({name, "_perr"}, 64'(out_parity_err), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_drops"}, 64'(|drop_cnt), 64'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [NCH-1:0] valid;
        int             seqb;
        logic           ready;
        logic           exp_ov;
        int             exp_lane;
        int             exp_seqb;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [63:0] r;

        tbl[0] = '{5'h1F, 100, 1'b1, 1'b0, 0, 0};
        tbl[1] = '{5'h00, 0,   1'b1, 1'b1, 0, 100};
        tbl[2] = '{5'h00, 0,   1'b1, 1'b1, 1, 100};
        tbl[3] = '{5'h00, 0,   1'b1, 1'b1, 2, 100};
        tbl[4] = '{5'h00, 0,   1'b1, 1'b1, 3, 100};
        tbl[5] = '{5'h00, 0,   1'b1, 1'b1, 4, 100};
        tbl[6] = '{5'h1F, 200, 1'b1, 1'b0, 0, 0};
        tbl[7] = '{5'h00, 0,   1'b1, 1'b1, 0, 200};
        tbl[8] = '{5'h00, 0,   1'b1, 1'b1, 1, 200};

        rst = 1'b1; lane_en = '1; pkt_valid = '0; pkt_raw = '0; perr = '0;
        cnt_clr = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        check_all_zero("reset");
        rst = 1'b0;

        // Single packet on lane 2: visible two edges after the strobe.
        set_lane(2, 34'h1_2345_6789, 1'b0);
        pkt_valid = 5'b00100;
        cycle();
        chk("single_early", 64'(out_valid), 64'd0);
        cycle();
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_lane", 64'(out_lane), 64'd2);
        chk("single_data", 64'(out_data), 64'h1_2345_6789);
        chk("single_drops", 64'(|drop_cnt), 64'd0);
        cycle();

        // Reset so lane 0 has first priority for the burst table.
        rst = 1'b1; #1; model_reset(); @(negedge clk); rst = 1'b0;

        for (int r_i = 0; r_i < 9; r_i++) begin
            out_ready = tbl[r_i].ready;
            for (int i = 0; i < NCH; i++)
                if (tbl[r_i].valid[i]) set_lane(i, mkpkt(i, tbl[r_i].seqb + i), i[0]);
            pkt_valid = tbl[r_i].valid;
            cycle();
            chk("tbl_valid", 64'(out_valid), 64'(tbl[r_i].exp_ov));
            if (tbl[r_i].exp_ov) begin
                chk("tbl_lane", 64'(out_lane), 64'(tbl[r_i].exp_lane));
                chk("tbl_data", 64'(out_data),
                    64'(mkpkt(tbl[r_i].exp_lane, tbl[r_i].exp_seqb + tbl[r_i].exp_lane)));
            end
        end
        repeat (5) cycle();

        // Collision: lane 3 granted in the cycle a new packet arrives.
        set_lane(3, mkpkt(3, 400), 1'b0); pkt_valid = 5'b01000;
        cycle();
        set_lane(3, mkpkt(3, 401), 1'b1); pkt_valid = 5'b01000;
        cycle();
        chk("coll_first", 64'(out_data), 64'(mkpkt(3, 400)));
        cycle();
        chk("coll_second_valid", 64'(out_valid), 64'd1);
        chk("coll_second", 64'(out_data), 64'(mkpkt(3, 401)));
        chk("coll_second_perr", 64'(out_parity_err), 64'd1);
        chk("coll_drops", 64'(drop_cnt[3*CNT_W +: CNT_W]), 64'd0);
        cycle();

        // Back-pressure: lane 1 strobes every cycle with out_ready low.
        out_ready = 1'b0;
        for (int n = 0; n <= 10; n++) begin
            set_lane(1, mkpkt(1, 300 + n), 1'b0); pkt_valid = 5'b00010;
            cycle();
            if (n >= 1) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'(out_data), 64'(mkpkt(1, 300)));
            end
        end
        chk("stall_drops", 64'(drop_cnt[1*CNT_W +: CNT_W]), 64'd9);
        out_ready = 1'b1;
        cycle();
        chk("stall_release", 64'(out_data), 64'(mkpkt(1, 301)));
        cycle();
        chk("stall_empty", 64'(out_valid), 64'd0);

        // Saturation of lane 0 drop counter, then clear concurrent with a drop.
        out_ready = 1'b0;
        for (int n = 0; n < 65536 + 5 + 2; n++) begin
            set_lane(0, mkpkt(0, 500), 1'b0); pkt_valid = 5'b00001;
            cycle();
        end
        chk("sat_value", 64'(drop_cnt[0 +: CNT_W]), 64'hFFFF);
        set_lane(0, mkpkt(0, 501), 1'b0); pkt_valid = 5'b00001; cnt_clr = 1'b1;
        cycle();
        chk("clr_wins", 64'(drop_cnt[0 +: CNT_W]), 64'd0);
        out_ready = 1'b1;
        repeat (3) cycle();

        // Idle-type packets: never emitted, never counted.
        for (int n = 0; n < 4; n++) begin
            set_lane(0, {4'h0, 30'h155}, 1'b0); pkt_valid = 5'b00001;
            cycle();
            chk("idle_valid", 64'(out_valid), 64'd0);
            chk("idle_drops", 64'(drop_cnt[0 +: CNT_W]), 64'd0);
        end

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < NCH; i++) set_lane(i, mkpkt(i, 600 + i), 1'b1);
        pkt_valid = '1;
        cycle();
        cycle();
        rst = 1'b1; #1;
        model_reset();
        check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b0;

        // First grant after reset goes to the lowest pending lane.
        set_lane(3, mkpkt(3, 700), 1'b0); set_lane(1, mkpkt(1, 701), 1'b0);
        pkt_valid = 5'b01010;
        cycle();
        cycle();
        chk("post_reset_first", 64'(out_lane), 64'd1);
        cycle();
        chk("post_reset_second", 64'(out_lane), 64'd3);
        cycle();

        // Lane 4 disabled while pending: held until re-enabled.
        set_lane(4, mkpkt(4, 800), 1'b0); pkt_valid = 5'b10000;
        cycle();
        lane_en = 5'b01111;
        for (int n = 0; n < 4; n++) begin
            cycle();
            chk("disabled_valid", 64'(out_valid), 64'd0);
            chk("disabled_busy", 64'(busy), 64'd1);
        end
        lane_en = '1;
        cycle();
        chk("reenable_lane", 64'(out_lane), 64'd4);
        chk("reenable_data", 64'(out_data), 64'(mkpkt(4, 800)));
        cycle();

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            lane_en   = ($urandom_range(0, 7) == 0) ? 5'($urandom()) : '1;
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < NCH; i++) begin
                r = {$urandom(), $urandom()};
                if ($urandom_range(0, 3) == 0) r[33:30] = 4'd0;
                set_lane(i, r[PKT_W-1:0], r[40]);
            end
            pkt_valid = 5'($urandom());
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
